tw_horizontal_loader: RTL
=========================

# tw_horizontal_loader

Transmitter side of the stage-0 horizontal twiddle-update interface. It accepts eight 64-bit words from the host side (four 128-bit twiddle entries as hi/lo pairs) into a staging buffer. On `start` it streams them to the twiddle ROM as one contiguous 8-cycle burst: four high halves with `ROM5_w`=1, then four low halves with `ROM5_w`=2. The ROM's internal index wraps 3→0 across the hi→lo boundary, so the burst must never contain a gap.

## Interface

Parameters:
- `HDW`, 64, half-entry data width (one 64-bit half of a 128-bit entry)
- `N_ENT`, 4, entries per burst; fixed at 4 to match the receiver index
- `IDX_W`, 2, entry index width; equals log2(`N_ENT`)

Ports:
- `CLK`  in  1  single clock; all state on rising edge
- `rst`  in  1  asynchronous, active-high reset
- `load_valid`  in  1  host word valid
- `load_data`  in  `HDW`  host word
- `load_ready`  out  1  word accepted when `load_valid`&&`load_ready`
- `start`  in  1  burst request, sampled each cycle
- `horizontal_tf_out`  out  `HDW`  half-entry to ROM
- `ROM5_w`  out  2  0=idle, 1=high half, 2=low half; 3 never driven
- `busy`  out  1  burst in progress
- `done`  out  1  one-cycle pulse after the last half
- `start_err`  out  1  one-cycle pulse when `start` is rejected
- `full`  out  1  all 8 words staged

## Operation

- Staging buffer: `stg[0..3]`, each 128 bits. A 3-bit fill count `fc` selects the slot.
- Load order: word `2e` → `stg[e][127:64]`, word `2e+1` → `stg[e][63:0]`.
- `load_ready` = IDLE && !`full`. Each accepted word increments `fc`. When `fc` wraps 7→0, `full` sets.
- FSM states: IDLE, HI, LO, DONE.
  - IDLE→HI: `start` && `full`. The send index `si` is cleared.
  - HI: drive `ROM5_w`=1 and `stg[si][127:64]`, with `si`++. When `si`==3 → LO, and `si` wraps to 0.
  - LO: drive `ROM5_w`=2 and `stg[si][63:0]`, with `si`++. When `si`==3 → DONE.
  - DONE: `ROM5_w`=0, `done`=1 for one cycle, then → IDLE.
- `start` in IDLE with `full`=0: no burst, `start_err` pulses next cycle.
- `start` while in HI, LO or DONE: ignored, no error pulse.
- `load_valid` and `start` in the same cycle in IDLE:
  - With `full`=1, `load_ready`=0 so no word is taken, and the burst starts.
  - With `full`=0, the word is accepted, `start_err` pulses, and no burst starts. The registered `full` is used.
- `horizontal_tf_out` is 0 whenever `ROM5_w`=0.
- Reset values, applied asynchronously (also mid-burst):
  - Outputs: `ROM5_w`=0, `horizontal_tf_out`=0, `busy`=0, `done`=0, `start_err`=0, `full`=0, `load_ready`=1.
  - Internal: `stg` all zero, `fc`=0, `si`=0, state IDLE.
  - An aborted burst is not resumed.

## Timing

- All outputs are registered.
- `start` accepted at edge T:
  - T+1..T+4: `ROM5_w`=1 with hi0..hi3.
  - T+5..T+8: `ROM5_w`=2 with lo0..lo3.
  - T+9: `ROM5_w`=0 and `done`=1.
- `busy` is high during T+1..T+8.
- Latency from `start` to the first half is 1 cycle. Burst length is exactly 8 consecutive cycles; the FSM has no stall input.
- `load_ready` returns to 1 at T+10 at the earliest, and only if `full` is cleared.
- A new `start` is accepted at T+10 at the earliest.
- `start_err` appears one cycle after the rejected `start`.

## Configuration

- `TW_LOADER_KEEP_EN` defined:
  - After DONE, `full` stays 1 and `stg` is retained.
  - A later `start` replays the same 8 halves without refilling.
  - `load_ready` stays 0 until reset.
- Not defined:
  - On DONE→IDLE, `full` clears and `fc`=0; `stg` contents are untouched but considered stale.
  - A refill of 8 words is required before the next `start`.

## Test plan

- Reset → all outputs at reset values, `load_ready`=1. Load words 0x11..0x18 → `full`=1 after the 8th, `load_ready`=0.
- Load as above, `start` at T → T+1..T+4 `ROM5_w`=1 with data 0x11,0x13,0x15,0x17; T+5..T+8 `ROM5_w`=2 with data 0x12,0x14,0x16,0x18; `done`=1 at T+9.
- `start` with only 5 words loaded → `start_err`=1 one cycle later, `ROM5_w` stays 0, and 3 more words are still accepted.
- `start` re-asserted during a burst → burst unchanged; no second burst and no `start_err`.
- `rst` pulsed at T+3 of a burst → `ROM5_w`=0 and `horizontal_tf_out`=0 immediately, `full`=0; a subsequent `start` → `start_err`.
- Second `start` after DONE:
  - With `TW_LOADER_KEEP_EN`: identical burst replayed.
  - Without it: `start_err`, and `load_ready`=1.

Source files
------------

// File: rtl/tw_horizontal_loader.sv
// tw_horizontal_loader: stages four 128-bit twiddle entries and bursts them to the ROM as 4 high halves then 4 low halves.
// Optional TW_LOADER_KEEP_EN keeps the staged entries after a burst so a later start replays them.
module tw_horizontal_loader #(
   parameter int HDW   = 64,
   parameter int N_ENT = 4,
   parameter int IDX_W = 2
) (
   input  logic           CLK,
   input  logic           rst,
   input  logic           load_valid,
   input  logic [HDW-1:0] load_data,
   output logic           load_ready,
   input  logic           start,
   output logic [HDW-1:0] horizontal_tf_out,
   output logic [1:0]     ROM5_w,
   output logic           busy,
   output logic           done,
   output logic           start_err,
   output logic           full
);
   typedef enum logic [1:0] {IDLE, HI, LO, DONE} state_t;
   state_t state, ns;
   logic [IDX_W-1:0] si, nsi;
   logic [2:0] fc;
   logic nfull, acc;
   logic [2*HDW-1:0] stg [N_ENT];
   always_comb begin
      ns = state;
      nsi = si;
      acc = load_valid && load_ready;
      case (state)
         IDLE: if (start && full) begin
            ns = HI;
            nsi = '0;
         end
         HI: begin
            nsi = si + 1'b1;
            if (si == IDX_W'(N_ENT-1)) ns = LO;
         end
         LO: begin
            nsi = si + 1'b1;
            if (si == IDX_W'(N_ENT-1)) ns = DONE;
         end
         default: ns = IDLE;
      endcase
`ifdef TW_LOADER_KEEP_EN
      nfull = full || (acc && fc == 3'd7);
`else
      nfull = (state == DONE) ? 1'b0 : full || (acc && fc == 3'd7);
`endif
   end
   // outputs are registered from the next state so each half appears the cycle its state begins
   always_ff @(posedge CLK or posedge rst) begin
      if (rst) begin
         state <= IDLE;
         si <= '0;
         fc <= '0;
         full <= 1'b0;
         load_ready <= 1'b1;
         ROM5_w <= 2'd0;
         horizontal_tf_out <= '0;
         busy <= 1'b0;
         done <= 1'b0;
         start_err <= 1'b0;
         for (int i = 0; i < N_ENT; i++) stg[i] <= '0;
      end else begin
         state <= ns;
         si <= nsi;
         full <= nfull;
         if (acc) begin
            if (fc[0]) stg[fc[2:1]][HDW-1:0] <= load_data;
            else stg[fc[2:1]][2*HDW-1:HDW] <= load_data;
            fc <= fc + 3'd1;
         end
`ifndef TW_LOADER_KEEP_EN
         if (state == DONE) fc <= '0;
`endif
         load_ready <= (ns == IDLE) && !nfull;
         ROM5_w <= (ns == HI) ? 2'd1 : (ns == LO) ? 2'd2 : 2'd0;
         horizontal_tf_out <= (ns == HI) ? stg[nsi][2*HDW-1:HDW] : (ns == LO) ? stg[nsi][HDW-1:0] : '0;
         busy <= (ns == HI) || (ns == LO);
         done <= (ns == DONE);
         start_err <= (state == IDLE) && start && !full;
      end
   end
endmodule
